// File: rtl/regfile_pkg.sv
// Shared writeback definitions: default widths, source encodings and the zero-register index.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // The requester that loses contention against the given winner.
    function automatic wb_src_e other_src(input wb_src_e src);
        return (src == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_grant.sv
// Combinational grant logic for the two writeback requesters; holds no state.
module wb_grant
    import regfile_pkg::*;
(
    input  logic    alu_valid,
    input  logic    mem_valid,
    input  logic    block,
    input  wb_src_e favour,
    output logic    alu_gnt,
    output logic    mem_gnt,
    output logic    contended
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        alu_gnt   = 1'b0;
        mem_gnt   = 1'b0;
        contended = alu_valid && mem_valid;
        if (!block) begin
            if (contended) begin
                alu_gnt = (favour == SRC_ALU);
                mem_gnt = (favour == SRC_MEM);
            end else begin
                alu_gnt = alu_valid;
                mem_gnt = mem_valid;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Define WB_ROUND_ROBIN_EN for an alternating priority pointer; otherwise MEM always wins contention.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rf_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_src,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic    alu_gnt;
    logic    mem_gnt;
    logic    contended;
    wb_src_e favour;

    logic              wr_en_d,        wr_en_q;
    logic [ADDR_W-1:0] wr_addr_d,      wr_addr_q;
    logic [DATA_W-1:0] wr_data_d,      wr_data_q;
    wb_src_e           wr_src_d,       wr_src_q;
    logic [CNT_W-1:0]  conflict_cnt_d, conflict_cnt_q;

`ifdef WB_ROUND_ROBIN_EN
    wb_src_e prio_d, prio_q;
    assign favour = prio_q;
`else
    assign favour = SRC_MEM;
`endif

    // Reset also blocks grants so neither requester sees ready while rst is high.
    wb_grant u_grant (
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .block     (rf_busy || rst),
        .favour    (favour),
        .alu_gnt   (alu_gnt),
        .mem_gnt   (mem_gnt),
        .contended (contended)
    );

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    always_comb begin
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        wr_src_d       = wr_src_q;
        conflict_cnt_d = conflict_cnt_q;

        if (mem_gnt) begin
            wr_en_d   = (mem_addr != ADDR_W'(ZERO_REG));
            wr_addr_d = mem_addr;
            wr_data_d = mem_data;
            wr_src_d  = SRC_MEM;
        end else if (alu_gnt) begin
            wr_en_d   = (alu_addr != ADDR_W'(ZERO_REG));
            wr_addr_d = alu_addr;
            wr_data_d = alu_data;
            wr_src_d  = SRC_ALU;
        end

        // Contention is counted even while the write port is busy.
        if (contended && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    always_comb begin
        prio_d = prio_q;
        if (contended && (alu_gnt || mem_gnt)) begin
            prio_d = other_src(prio_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= SRC_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_src_q       <= SRC_ALU;
            conflict_cnt_q <= '0;
        end else begin
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            wr_src_q       <= wr_src_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_src       = wr_src_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases plus hold-until-accepted random traffic.
module tb_regfile_wb_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              rf_busy = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;
    logic [CNT_W-1:0]  conflict_cnt;

    regfile_wb_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .rf_busy      (rf_busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        int unsigned addr;
        int unsigned data;
        bit          src;
        int unsigned cnt;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;
    int      tests = 0;
    int      fails = 0;

    // Reference model state: priority favours MEM when m_prio is 1.
    bit          m_prio = 1'b0;
    int unsigned m_cnt  = 0;
    wb_exp_t     m_last = '{default: 0};
    bit          a_acc;
    bit          m_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("wr_en",        64'(wr_en),        64'(mon_e.en));
            check("wr_addr",      64'(wr_addr),      64'(mon_e.addr));
            check("wr_data",      64'(wr_data),      64'(mon_e.data));
            check("wr_src",       64'(wr_src),       64'(mon_e.src));
            check("conflict_cnt", 64'(conflict_cnt), 64'(mon_e.cnt));
        end
    end

    // One cycle of stimulus: present inputs, check readies, predict next-cycle outputs.
    task automatic drive(input bit av, input int unsigned aa, input int unsigned ad,
                         input bit mv, input int unsigned ma, input int unsigned md,
                         input bit busy);
        bit      favour_mem;
        bit      exp_a;
        bit      exp_m;
        wb_exp_t e;
        @(negedge clk);
        alu_valid = av;
        alu_addr  = ADDR_W'(aa);
        alu_data  = DATA_W'(ad);
        mem_valid = mv;
        mem_addr  = ADDR_W'(ma);
        mem_data  = DATA_W'(md);
        rf_busy   = busy;
        #1;
`ifdef WB_ROUND_ROBIN_EN
        favour_mem = m_prio;
`else
        favour_mem = 1'b1;
`endif
        exp_a = av && !busy && (!mv || !favour_mem);
        exp_m = mv && !busy && (!av || favour_mem);
        check("alu_ready", 64'(alu_ready), 64'(exp_a));
        check("mem_ready", 64'(mem_ready), 64'(exp_m));
        if (av && mv) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (!busy) m_prio = !m_prio;
        end
        e    = m_last;
        e.en = 1'b0;
        if (exp_a || exp_m) begin
            e.src  = exp_m;
            e.addr = exp_m ? ma : aa;
            e.data = exp_m ? md : ad;
            e.en   = (e.addr != 0);
        end
        e.cnt  = m_cnt;
        m_last = e;
        sb_q.push_back(e);
        a_acc = exp_a;
        m_acc = exp_m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_checks();
        check("rst_wr_en",     64'(wr_en),        64'd0);
        check("rst_wr_addr",   64'(wr_addr),      64'd0);
        check("rst_wr_data",   64'(wr_data),      64'd0);
        check("rst_wr_src",    64'(wr_src),       64'd0);
        check("rst_cnt",       64'(conflict_cnt), 64'd0);
        check("rst_alu_ready", 64'(alu_ready),    64'd0);
        check("rst_mem_ready", 64'(mem_ready),    64'd0);
    endtask

    // Reset asserted just after the monitor samples the current cycle's write.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        rf_busy   = 1'b0;
        rst       = 1'b1;
        #1;
        reset_checks();
        @(negedge clk);
        rst       = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        m_prio    = 1'b0;
        m_cnt     = 0;
        m_last    = '{default: 0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ap;
        bit          mp;
        int unsigned ra_addr;
        int unsigned ra_data;
        int unsigned rm_addr;
        int unsigned rm_data;

        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #3;
        reset_checks();
        @(negedge clk);
        rst       = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        drive(1, 5, 32'h1234, 0, 0, 0, 0);
        idle(1);

        mid_reset();
        for (int i = 0; i < 4; i++) drive(1, 3, 32'hA000 + i, 1, 7, 32'hB000 + i, 0);
        idle(1);

        drive(0, 0, 0, 1, 0, 32'hDEAD, 0);
        idle(1);

        for (int i = 0; i < 3; i++) drive(1, 12, 32'hCAFE, 0, 0, 0, 1);
        drive(1, 12, 32'hCAFE, 0, 0, 0, 0);
        idle(1);

        drive(1, 9, 32'h55, 0, 0, 0, 0);
        mid_reset();
        drive(1, 4, 32'h77, 1, 4, 32'h88, 0);
        drive(1, 4, 32'h77, 1, 4, 32'h88, 0);
        idle(1);

        for (int i = 0; i < 20; i++) drive(1, 1 + i, i, 1, 31 - i, ~i, $urandom_range(3, 0) == 0);
        idle(1);

        ap = 1'b0;
        mp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!ap && ($urandom_range(1, 0) == 1)) begin
                ap      = 1'b1;
                ra_addr = $urandom_range(31, 0);
                ra_data = $urandom;
            end
            if (!mp && ($urandom_range(1, 0) == 1)) begin
                mp      = 1'b1;
                rm_addr = $urandom_range(31, 0);
                rm_data = $urandom;
            end
            drive(ap, ra_addr, ra_data, mp, rm_addr, rm_data, $urandom_range(3, 0) == 0);
            if (a_acc) ap = 1'b0;
            if (m_acc) mp = 1'b0;
            if (i == 200) mid_reset();
        end
        idle(2);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
